// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with dead time and leading-zero blanking.
// Optional PWM brightness control is enabled by defining SEG_SCAN_PWM_EN.
//
// state | meaning
// IDLE  | scan stopped, all pins dark, waiting for enable
// BLANK | all anodes off for BLANK_CYCLES before the next digit
// SHOW  | anode idx_q active for DIGIT_CYCLES
module seg_scan_ctrl #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        reset,
`ifdef SEG_SCAN_PWM_EN
  input  logic [3:0]  brightness,
`endif
  input  logic        enable,
  input  logic [15:0] number,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank_en,
  output logic [3:0]  digit,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        frame_tick
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam logic [CNT_W-1:0] DIG_LOAD   = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit               NO_BLANK   = (BLANK_CYCLES == 0);

  state_t           state_q;
  logic [1:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      snap_q;
  logic [3:0]       snap_dp_q;

  logic [3:0]       digit_q, digit_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_tick_q;

  logic [3:0]       code;
  logic             blank;

`ifdef SEG_SCAN_PWM_EN
  logic [3:0]       pwm_cnt_q;
`endif

  function automatic logic [6:0] decode7(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Pin values for the current state; registered below so pins lag the state by one cycle.
  always_comb begin
    case (idx_q)
      2'd1:    code = snap_q[7:4];
      2'd2:    code = snap_q[11:8];
      2'd3:    code = snap_q[15:12];
      default: code = snap_q[3:0];
    endcase

    blank = 1'b0;
    if (lz_blank_en) begin
      case (idx_q)
        2'd3:    blank = (snap_q[15:12] == 4'h0);
        2'd2:    blank = (snap_q[15:8]  == 8'h00);
        2'd1:    blank = (snap_q[15:4]  == 12'h000);
        default: blank = 1'b0;
      endcase
    end

    digit_d = 4'hF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (state_q == SHOW) begin
      digit_d = ~(4'b0001 << idx_q);
      seg_d   = blank ? 7'h7F : decode7(code);
      dp_d    = ~snap_dp_q[idx_q];
`ifdef SEG_SCAN_PWM_EN
      if (pwm_cnt_q > brightness) digit_d = 4'hF;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      snap_q       <= 16'h0000;
      snap_dp_q    <= 4'h0;
      digit_q      <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else if (!enable) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      digit_q      <= 4'hF;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      digit_q      <= digit_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          snap_q    <= number;
          snap_dp_q <= dp_in;
          if (NO_BLANK) begin
            state_q <= SHOW;
            cnt_q   <= DIG_LOAD;
          end else begin
            state_q <= BLANK;
            cnt_q   <= BLANK_LOAD;
          end
        end
        BLANK: begin
          if (cnt_q == '0) begin
            state_q <= SHOW;
            cnt_q   <= DIG_LOAD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt_q == '0) begin
            idx_q <= idx_q + 2'd1;
            // Frame boundary: reload the snapshot so a frame never mixes old and new values.
            if (idx_q == 2'd3) begin
              frame_tick_q <= 1'b1;
              snap_q       <= number;
              snap_dp_q    <= dp_in;
            end
            if (NO_BLANK) begin
              state_q <= SHOW;
              cnt_q   <= DIG_LOAD;
            end else begin
              state_q <= BLANK;
              cnt_q   <= BLANK_LOAD;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef SEG_SCAN_PWM_EN
  // Restarts at every slot so each digit gets the same duty regardless of slot length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= 4'h0;
    end else if (enable && state_q == SHOW && cnt_q != '0) begin
      pwm_cnt_q <= pwm_cnt_q + 4'h1;
    end else begin
      pwm_cnt_q <= 4'h0;
    end
  end
`endif

  assign digit      = digit_q;
  assign segments   = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: one instance with dead time, one without.
module tb_seg_scan_ctrl;

  localparam logic [12:0] OFF = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] number = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_blank_en = 1'b0;
`ifdef SEG_SCAN_PWM_EN
  logic [3:0]  brightness = 4'hF;
`endif

  logic [3:0]  digit_a, digit_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, ft_a, ft_b;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset),
`ifdef SEG_SCAN_PWM_EN
    .brightness(brightness),
`endif
    .enable(enable), .number(number), .dp_in(dp_in), .lz_blank_en(lz_blank_en),
    .digit(digit_a), .segments(seg_a), .dp(dp_a), .frame_tick(ft_a)
  );

  seg_scan_ctrl #(.DIGIT_CYCLES(8), .BLANK_CYCLES(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset(reset),
`ifdef SEG_SCAN_PWM_EN
    .brightness(brightness),
`endif
    .enable(enable), .number(number), .dp_in(dp_in), .lz_blank_en(lz_blank_en),
    .digit(digit_b), .segments(seg_b), .dp(dp_b), .frame_tick(ft_b)
  );

  typedef struct {
    logic [15:0]     num;
    logic [3:0]      dpi;
    logic            lz;
    bit              use0;
    logic [3:0][6:0] segs;   // expected {d3,d2,d1,d0}
  } vec_t;

  vec_t vecs[11];

  task automatic cmp(input bit use0, input logic [12:0] exp, input string name,
                     input int a, input int b);
    logic [12:0] act;
    act = use0 ? {digit_b, seg_b, dp_b, ft_b} : {digit_a, seg_a, dp_a, ft_a};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s [%0d,%0d] {digit,seg,dp,tick} got=%h want=%h", name, a, b, act, exp);
    end
  endtask

  task automatic start_scan(input logic [15:0] num, input logic [3:0] dpi,
                            input logic lz, input bit use0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    number = num;
    dp_in = dpi;
    lz_blank_en = lz;
    enable = 1'b1;
    @(negedge clk);
    cmp(use0, OFF, "idle_out", 0, 0);
  endtask

  // One full frame at the pins; optionally changes number after cycle chg_k.
  task automatic check_frame(input bit use0, input logic [3:0][6:0] segs,
                             input logic [3:0] dpi, input string name,
                             input int chg_k, input logic [15:0] chg_num);
    int blk;
    int k;
    logic [3:0] an;
    logic [12:0] exp;
    blk = use0 ? 0 : 2;
    k = 0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < blk + 8; c++) begin
        @(negedge clk);
        if (c < blk) begin
          exp = OFF;
        end else begin
          an = 4'b0001 << d;
          exp = {~an, segs[d], ~dpi[d], (d == 3 && c == blk + 7)};
        end
        cmp(use0, exp, name, d, c);
        if (k == chg_k) number = chg_num;
        k++;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{16'h1234, 4'h0, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1]  = '{16'h0070, 4'h0, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h78, 7'h40}};
    vecs[2]  = '{16'h0070, 4'h0, 1'b0, 1'b0, {7'h40, 7'h40, 7'h78, 7'h40}};
    vecs[3]  = '{16'hEF56, 4'h8, 1'b1, 1'b0, {7'h06, 7'h0E, 7'h12, 7'h02}};
    vecs[4]  = '{16'h0000, 4'h2, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[5]  = '{16'h0809, 4'h0, 1'b1, 1'b0, {7'h7F, 7'h00, 7'h40, 7'h10}};
    vecs[6]  = '{16'h89A0, 4'hF, 1'b0, 1'b0, {7'h00, 7'h10, 7'h08, 7'h40}};
    vecs[7]  = '{16'h00BC, 4'h0, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h03, 7'h46}};
    vecs[8]  = '{16'h0D07, 4'h4, 1'b1, 1'b0, {7'h7F, 7'h21, 7'h40, 7'h78}};
    vecs[9]  = '{16'hABCD, 4'h5, 1'b0, 1'b1, {7'h08, 7'h03, 7'h46, 7'h21}};
    vecs[10] = '{16'h0070, 4'h1, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}};

    // Reset state
    #2 reset = 1'b1;
    #2;
    cmp(1'b0, OFF, "reset_a", 0, 0);
    cmp(1'b1, OFF, "reset_b", 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven frames
    for (int i = 0; i < 11; i++) begin
      start_scan(vecs[i].num, vecs[i].dpi, vecs[i].lz, vecs[i].use0);
      check_frame(vecs[i].use0, vecs[i].segs, vecs[i].dpi, "vec", -1, 16'h0000);
      if (i == 0)
        check_frame(1'b0, vecs[0].segs, vecs[0].dpi, "vec0_repeat", -1, 16'h0000);
    end

    // Mid-frame number change is deferred to the next frame
    start_scan(16'h1111, 4'h0, 1'b0, 1'b0);
    check_frame(1'b0, {7'h79, 7'h79, 7'h79, 7'h79}, 4'h0, "snap_old", 15, 16'h2222);
    check_frame(1'b0, {7'h24, 7'h24, 7'h24, 7'h24}, 4'h0, "snap_new", -1, 16'h0000);

    // Disable during d2's slot, then restart
    start_scan(16'h1234, 4'h0, 1'b0, 1'b0);
    repeat (25) @(negedge clk);
    cmp(1'b0, {4'b1011, 7'h24, 1'b1, 1'b0}, "pre_disable_d2", 2, 0);
    enable = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cmp(1'b0, OFF, "disabled_off", 0, c);
    end
    start_scan(16'h1234, 4'h0, 1'b0, 1'b0);
    check_frame(1'b0, vecs[0].segs, 4'h0, "reenable", -1, 16'h0000);

    // Asynchronous reset mid-scan
    start_scan(16'h1234, 4'h0, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    cmp(1'b0, OFF, "rst_mid_a", 0, 0);
    cmp(1'b1, OFF, "rst_mid_b", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    start_scan(16'h1234, 4'h0, 1'b0, 1'b0);
    check_frame(1'b0, vecs[0].segs, 4'h0, "after_rst", -1, 16'h0000);

`ifdef SEG_SCAN_PWM_EN
    for (int p = 0; p < 2; p++) begin
      int on_cnt;
      brightness = (p == 0) ? 4'd3 : 4'd15;
      start_scan(16'h1234, 4'h0, 1'b0, 1'b0);
      for (int d = 0; d < 4; d++) begin
        on_cnt = 0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (digit_a != 4'hF) on_cnt++;
        end
        compared++;
        if (on_cnt != ((p == 0) ? 4 : 8)) begin
          mismatched++;
          $display("FAIL pwm_duty digit %0d got=%0d want=%0d", d, on_cnt, (p == 0) ? 4 : 8);
        end
      end
    end
    brightness = 4'hF;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
